inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Fetch sequencer that drives the instruction register from program memory.
- Holds the program counter (PC) and a 2-level return stack.
- Issues read requests to program memory and delivers each returned word on inst_out with a valid strobe.
- On any control-flow redirect it asserts skip_out, so the downstream instruction register loads a NOP (all-zero word).

Parameters:
PC_WIDTH, 9, width of PC, stack entries and mem_addr
INST_WIDTH, 12, instruction word width
RESET_VECTOR, 9'h1FF, PC value loaded at reset

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  synchronous, active-low reset; sampled on clock rising edge
stall  input  1  core stall; holds delivery and blocks new requests
branch  input  1  redirect the PC to branch_target (GOTO / computed jump)
call  input  1  push the PC, then redirect to branch_target
ret  input  1  pop the return stack into the PC
branch_target  input  PC_WIDTH  target for branch or call
mem_addr  output  PC_WIDTH  program memory read address (registered)
mem_rd  output  1  read request; held high until mem_ready
mem_ready  input  1  memory has accepted the read; mem_data is valid this cycle
mem_data  input  INST_WIDTH  returned instruction word
inst_out  output  INST_WIDTH  delivered instruction word
inst_valid  output  1  inst_out is valid this cycle
skip_out  output  1  one-cycle pulse on redirect; drives the instruction register's skip
pc  output  PC_WIDTH  address of the next word to fetch
stack_err  output  1  sticky flag: stack overflow or underflow has occurred

Behaviour:
- Reset (reset_n=0 at a clock edge), applies in any state, including mid-request:
  - PC=RESET_VECTOR; mem_addr=0, mem_rd=0; inst_out=0, inst_valid=0, skip_out=0.
  - Both stack entries=0, depth counter=0, stack_err=0, hold buffer empty, state=IDLE.
  - An outstanding request is abandoned; mem_ready is ignored in IDLE.
- State machine: IDLE, REQ, FLUSH, GAP.
  - IDLE -> REQ on the first cycle after reset is released, if stall=0.
  - REQ:
    - mem_rd=1, mem_addr=PC.
    - On mem_ready: the word goes to inst_out with inst_valid=1 on the next cycle. If stall=1, the word goes to the hold buffer instead.
    - PC <= PC+1, wrapping modulo 2^PC_WIDTH (9'h1FF -> 9'h000). State -> GAP.
  - GAP: mem_rd=0 for one cycle, then -> REQ if stall=0; otherwise stay in GAP. Sustained throughput is one word per 2 cycles.
  - FLUSH: entered when a redirect arrives while mem_rd=1. Stay until mem_ready; discard that mem_data (no inst_valid); then -> REQ at the new PC.
- stall:
  - While stall=1, inst_valid=0 and no new request starts.
  - A request already in flight completes; its word goes to the 1-entry hold buffer.
  - It is presented with inst_valid=1 on the first cycle stall=0.
  - A hold buffer that is already full blocks REQ entry.
- Redirect priority when more than one is asserted in the same cycle: ret > call > branch. Lower-priority inputs are ignored that cycle. Redirects are ignored while stall=1.
- Every redirect:
  - PC updated on the next edge.
  - skip_out=1 for exactly one cycle.
  - Hold buffer cleared; any delivery in that cycle is suppressed (inst_valid=0).
  - Next state is FLUSH if mem_rd=1, else REQ.
- call:
  - stack[1] <= stack[0]; stack[0] <= PC (already the return address).
  - Depth counter saturates at 2. A push at depth 2 loses stack[1] and sets stack_err.
- ret:
  - PC <= stack[0]; stack[0] <= stack[1]; stack[1] unchanged.
  - A pop at depth 0 still loads stack[0] and sets stack_err.
- stack_err clears only on reset.

Optional Feature:
- Macro: INST_FETCH_PREFETCH_EN.
- Defined: the GAP state is removed.
  - On mem_ready in REQ, mem_rd stays high and mem_addr advances to PC+1 on the next edge.
  - Throughput is one word per cycle while mem_ready=1 and stall=0.
  - If stall=1 when mem_ready arrives, mem_rd drops until the hold buffer drains.
- Undefined: GAP behaviour as above, 2-cycle minimum per word.

Test Plan:
- Reset then release, mem_ready=1, mem_data=12'hA05 -> first mem_addr=9'h1FF; inst_out=12'hA05 with inst_valid; pc wraps to 9'h000; next fetch at 9'h000.
- Sequential fetch from 0 with mem_ready always 1 -> addresses 0,1,2,3; inst_valid every 2nd cycle (every cycle with INST_FETCH_PREFETCH_EN).
- branch=1, target=9'h040, while mem_rd=1 with mem_ready delayed 3 cycles -> skip_out pulses 1 cycle; returned word discarded; next mem_addr=9'h040.
- call to 9'h100 at pc=9'h011, then call to 9'h180, then a third call, then ret x3 -> returns to 9'h181, then 9'h101, then 9'h101 again; stack_err=1 after the third call.
- stall=1 asserted while a request is pending, mem_data=12'h3FF -> inst_valid stays 0; 12'h3FF delivered on the cycle stall drops; no second request during stall.
- ret, call and branch asserted in the same cycle -> ret is taken, the stack is not pushed, and exactly one skip_out pulse is produced.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : fetch sequencer (PC, 2-entry return stack, 1-entry hold buffer)
// Option     : `define INST_FETCH_PREFETCH_EN for back-to-back requests (no GAP)
// Revision   : 1.0
// ============================================================================
module inst_fetch #(
  parameter int                  PC_WIDTH     = 9,
  parameter int                  INST_WIDTH   = 12,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 9'h1FF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  branch,
  input  logic                  call,
  input  logic                  ret,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [PC_WIDTH-1:0]   mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ready,
  input  logic [INST_WIDTH-1:0] mem_data,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  inst_valid,
  output logic                  skip_out,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  stack_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [INST_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  skip_q, skip_d;
  logic [PC_WIDTH-1:0]   stack0_q, stack0_d;
  logic [PC_WIDTH-1:0]   stack1_q, stack1_d;
  logic [1:0]            depth_q, depth_d;
  logic                  err_q, err_d;

  logic                  redirect;
  logic                  mem_rd_o;
  logic                  accept;
  logic                  deliver;
  logic [PC_WIDTH-1:0]   pc_inc;

`ifdef INST_FETCH_PREFETCH_EN
  // A stalled, still-full hold buffer cannot take another word, so withdraw the request.
  assign mem_rd_o = mem_rd_q & ~(buf_full_q & stall);
`else
  assign mem_rd_o = mem_rd_q;
`endif

  assign redirect = ~stall & (ret | call | branch);
  assign accept   = mem_rd_o & mem_ready;
  assign deliver  = buf_full_q & ~stall & ~redirect;
  assign pc_inc   = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    skip_d     = redirect;
    stack0_d   = stack0_q;
    stack1_d   = stack1_q;
    depth_d    = depth_q;
    err_d      = err_q;

    if (redirect) begin
      buf_full_d = 1'b0;
      if (ret) begin
        pc_d     = stack0_q;
        stack0_d = stack1_q;
        if (depth_q == 2'd0) err_d = 1'b1;
        else                 depth_d = depth_q - 2'd1;
      end else if (call) begin
        pc_d     = branch_target;
        stack0_d = pc_q;
        stack1_d = stack0_q;
        if (depth_q == 2'd2) err_d = 1'b1;
        else                 depth_d = depth_q + 2'd1;
      end else begin
        pc_d = branch_target;
      end
    end else if (deliver) begin
      buf_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (!stall) begin
          state_d    = ST_REQ;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_d;
        end
      end
      ST_REQ: begin
        if (accept) begin
          // A redirect landing on the completing cycle drops the word and restarts at once.
          if (redirect) begin
            mem_addr_d = pc_d;
          end else begin
            buf_d      = mem_data;
            buf_full_d = 1'b1;
            pc_d       = pc_inc;
`ifdef INST_FETCH_PREFETCH_EN
            if (stall) begin
              state_d  = ST_IDLE;
              mem_rd_d = 1'b0;
            end else begin
              mem_addr_d = pc_d;
            end
`else
            state_d  = ST_GAP;
            mem_rd_d = 1'b0;
`endif
          end
        end else if (redirect) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          if (stall) begin
            state_d  = ST_IDLE;
            mem_rd_d = 1'b0;
          end else begin
            state_d    = ST_REQ;
            mem_addr_d = pc_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      skip_q     <= 1'b0;
      stack0_q   <= '0;
      stack1_q   <= '0;
      depth_q    <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      skip_q     <= skip_d;
      stack0_q   <= stack0_d;
      stack1_q   <= stack1_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_o;
  assign inst_out   = buf_q;
  assign inst_valid = deliver;
  assign skip_out   = skip_q;
  assign pc         = pc_q;
  assign stack_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : cycle-table bench for inst_fetch (default build)
// Revision      : 1.0
// ============================================================================
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset_n, stall, branch, call, ret, mem_ready;
  logic [8:0]  branch_target;
  logic [11:0] mem_data;
  logic [8:0]  mem_addr, pc;
  logic        mem_rd, inst_valid, skip_out, stack_err;
  logic [11:0] inst_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  inst_fetch dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branch(branch),
    .call(call), .ret(ret), .branch_target(branch_target),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .mem_data(mem_data), .inst_out(inst_out), .inst_valid(inst_valid),
    .skip_out(skip_out), .pc(pc), .stack_err(stack_err)
  );

  typedef struct {
    logic        rstn, stl, br, cl, rt;
    logic [8:0]  tgt;
    logic        rdy;
    logic [11:0] data;
    logic        e_rd;
    logic [8:0]  e_addr;
    logic        e_vld;
    logic [11:0] e_out;
    logic        e_skip;
    logic [8:0]  e_pc;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic rstn, stl, br, cl, rt, input logic [8:0] tgt,
    input logic rdy, input logic [11:0] data,
    input logic e_rd, input logic [8:0] e_addr, input logic e_vld,
    input logic [11:0] e_out, input logic e_skip, input logic [8:0] e_pc,
    input logic e_err);
    vec_t v;
    v.rstn = rstn; v.stl = stl; v.br = br; v.cl = cl; v.rt = rt;
    v.tgt = tgt; v.rdy = rdy; v.data = data;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_vld = e_vld; v.e_out = e_out;
    v.e_skip = e_skip; v.e_pc = e_pc; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input string tag, input int row,
                     input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s[%0d]: got %h expected %h", nm, tag, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check on the falling edge, then cross the rising edge.
  task automatic cyc(input vec_t v, input string tag, input int row);
    reset_n = v.rstn; stall = v.stl; branch = v.br; call = v.cl; ret = v.rt;
    branch_target = v.tgt; mem_ready = v.rdy; mem_data = v.data;
    @(negedge clock);
    chk("mem_rd",     tag, row, 12'(mem_rd),     12'(v.e_rd));
    chk("mem_addr",   tag, row, 12'(mem_addr),   12'(v.e_addr));
    chk("inst_valid", tag, row, 12'(inst_valid), 12'(v.e_vld));
    if (v.e_vld) chk("inst_out", tag, row, inst_out, v.e_out);
    chk("skip_out",   tag, row, 12'(skip_out),   12'(v.e_skip));
    chk("pc",         tag, row, 12'(pc),         12'(v.e_pc));
    chk("stack_err",  tag, row, 12'(stack_err),  12'(v.e_err));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    branch_target = '0; mem_ready = 1'b0; mem_data = '0;

    //                 rs st br cl rt tgt     rdy data      rd addr    vld out      sk pc      err
    tbl.push_back(mk(0, 0, 0, 0, 0, 9'h000, 0, 12'h000,  0, 9'h000, 0, 12'h000, 0, 9'h1FF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'hA05,  0, 9'h000, 0, 12'h000, 0, 9'h1FF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'hA05,  1, 9'h1FF, 0, 12'h000, 0, 9'h1FF, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h123,  0, 9'h1FF, 1, 12'hA05, 0, 9'h000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h111,  1, 9'h000, 0, 12'h000, 0, 9'h000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h000,  0, 9'h000, 1, 12'h111, 0, 9'h001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h222,  1, 9'h001, 0, 12'h000, 0, 9'h001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h000,  0, 9'h001, 1, 12'h222, 0, 9'h002, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h333,  1, 9'h002, 0, 12'h000, 0, 9'h002, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h000,  0, 9'h002, 1, 12'h333, 0, 9'h003, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h444,  1, 9'h003, 0, 12'h000, 0, 9'h003, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h000,  0, 9'h003, 1, 12'h444, 0, 9'h004, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 9'h011, 0, 12'h000,  1, 9'h004, 0, 12'h000, 0, 9'h004, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'hFFF,  1, 9'h004, 0, 12'h000, 1, 9'h011, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 9'h100, 0, 12'h000,  1, 9'h011, 0, 12'h000, 0, 9'h011, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h555,  1, 9'h011, 0, 12'h000, 1, 9'h100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h7C1,  1, 9'h100, 0, 12'h000, 0, 9'h100, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 9'h180, 1, 12'h000,  0, 9'h100, 0, 12'h000, 0, 9'h101, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h0C3,  1, 9'h180, 0, 12'h000, 1, 9'h180, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 9'h1C0, 1, 12'h000,  0, 9'h180, 0, 12'h000, 0, 9'h181, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 9'h000, 0, 12'h000,  1, 9'h1C0, 0, 12'h000, 1, 9'h1C0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h999,  1, 9'h1C0, 0, 12'h000, 1, 9'h181, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 9'h000, 0, 12'h000,  1, 9'h181, 0, 12'h000, 0, 9'h181, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 9'h000, 0, 12'h000,  1, 9'h181, 0, 12'h000, 1, 9'h101, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h000,  1, 9'h181, 0, 12'h000, 1, 9'h101, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h101, 0, 12'h000, 0, 9'h101, 1));

    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], "seq", i);

    // Reset while a request is outstanding and memory answers during reset.
    cyc(mk(0, 0, 0, 0, 0, 9'h000, 1, 12'h5A5,  1, 9'h101, 0, 12'h000, 0, 9'h101, 1), "rst", 0);
    cyc(mk(0, 0, 0, 0, 0, 9'h000, 1, 12'h5A5,  0, 9'h000, 0, 12'h000, 0, 9'h1FF, 0), "rst", 1);
    chk("inst_out", "rst", 2, inst_out, 12'h000);

    // Branch while the request waits three cycles for memory; stale word is dropped.
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  0, 9'h000, 0, 12'h000, 0, 9'h1FF, 0), "flush", 0);
    cyc(mk(1, 0, 1, 0, 0, 9'h040, 0, 12'h000,  1, 9'h1FF, 0, 12'h000, 0, 9'h1FF, 0), "flush", 1);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h1FF, 0, 12'h000, 1, 9'h040, 0), "flush", 2);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h1FF, 0, 12'h000, 0, 9'h040, 0), "flush", 3);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'hBAD,  1, 9'h1FF, 0, 12'h000, 0, 9'h040, 0), "flush", 4);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h040, 0, 12'h000, 0, 9'h040, 0), "flush", 5);

    // Stall over a pending request: word parks in the hold buffer, redirect ignored.
    cyc(mk(1, 1, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h040, 0, 12'h000, 0, 9'h040, 0), "stall", 0);
    cyc(mk(1, 1, 0, 0, 0, 9'h000, 1, 12'h3FF,  1, 9'h040, 0, 12'h000, 0, 9'h040, 0), "stall", 1);
    cyc(mk(1, 1, 0, 0, 0, 9'h000, 0, 12'h000,  0, 9'h040, 0, 12'h000, 0, 9'h041, 0), "stall", 2);
    cyc(mk(1, 1, 1, 0, 0, 9'h077, 0, 12'h000,  0, 9'h040, 0, 12'h000, 0, 9'h041, 0), "stall", 3);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  0, 9'h040, 1, 12'h3FF, 0, 9'h041, 0), "stall", 4);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h041, 0, 12'h000, 0, 9'h041, 0), "stall", 5);

    // ret+call+branch together: pop wins (underflow), no push, single skip pulse.
    cyc(mk(1, 0, 1, 1, 1, 9'h0F0, 0, 12'h000,  1, 9'h041, 0, 12'h000, 0, 9'h041, 0), "prio", 0);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  1, 9'h041, 0, 12'h000, 1, 9'h000, 1), "prio", 1);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h001,  1, 9'h041, 0, 12'h000, 0, 9'h000, 1), "prio", 2);
    cyc(mk(1, 0, 0, 0, 1, 9'h000, 0, 12'h000,  1, 9'h000, 0, 12'h000, 0, 9'h000, 1), "prio", 3);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h002,  1, 9'h000, 0, 12'h000, 1, 9'h000, 1), "prio", 4);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 1, 12'h0A0,  1, 9'h000, 0, 12'h000, 0, 9'h000, 1), "prio", 5);
    cyc(mk(1, 0, 0, 0, 0, 9'h000, 0, 12'h000,  0, 9'h000, 1, 12'h0A0, 0, 9'h001, 1), "prio", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
